// File: rtl/score_board.sv
// score_board: Pong score keeper with 7-segment renderer; scores, win detection, restart by key.
// Optional winner-digit flashing is enabled by defining SCORE_FLASH_EN.
`default_nettype none

module score_board #(
    parameter int WIN_SCORE   = 7,
    parameter int P1_X        = 280,
    parameter int P2_X        = 340,
    parameter int DIGIT_Y     = 20,
    parameter int RESTART_KEY = 114,
    parameter int FLASH_DIV   = 12500000
) (
    input  logic       i_CLK,
    input  logic       i_RST_n,
    input  logic [9:0] i_display_x_pos,
    input  logic [9:0] i_display_y_pos,
    input  logic       i_hSync,
    input  logic       i_vSync,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_byte,
    output logic [2:0] o_red,
    output logic [2:0] o_green,
    output logic [2:0] o_blue,
    output logic       o_hSync,
    output logic       o_vSync,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic       o_game_over
);

    localparam logic [1:0] PLAYING = 2'd0;
    localparam logic [1:0] P1_WON  = 2'd1;
    localparam logic [1:0] P2_WON  = 2'd2;

    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    localparam logic [9:0] X1   = 10'(P1_X);
    localparam logic [9:0] X2   = 10'(P2_X);
    localparam logic [9:0] Y0   = 10'(DIGIT_Y);

    logic [1:0] state, state_next;
    logic [3:0] p1_score, p2_score, p1_next, p2_next;
    logic [1:0] p1_sync, p2_sync;
    logic       p1_prev, p2_prev;
    logic [1:0] arm_cnt;
    logic       armed, p1_edge, p2_edge, restart;

    // Edges stay masked until the synchronizer holds the real input level,
    // so a level already high at reset release is not counted.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            p1_sync <= 2'b00;
            p2_sync <= 2'b00;
            p1_prev <= 1'b0;
            p2_prev <= 1'b0;
            arm_cnt <= 2'd0;
        end else begin
            p1_sync <= {p1_sync[0], i_p1_scored};
            p2_sync <= {p2_sync[0], i_p2_scored};
            p1_prev <= p1_sync[1];
            p2_prev <= p2_sync[1];
            if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed   = (arm_cnt == 2'd3);
    assign p1_edge = armed && p1_sync[1] && !p1_prev;
    assign p2_edge = armed && p2_sync[1] && !p2_prev;
    assign restart = i_key_valid && (i_key_byte == 8'(RESTART_KEY));

    always_comb begin
        p1_next    = p1_score;
        p2_next    = p2_score;
        state_next = state;
        if (restart) begin
            p1_next    = 4'd0;
            p2_next    = 4'd0;
            state_next = PLAYING;
        end else if (state == PLAYING) begin
            if (p1_edge && p1_score < WIN) p1_next = p1_score + 4'd1;
            if (p2_edge && p2_score < WIN) p2_next = p2_score + 4'd1;
            if (p1_next == WIN)      state_next = P1_WON;
            else if (p2_next == WIN) state_next = P2_WON;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state       <= PLAYING;
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
            o_game_over <= 1'b0;
        end else begin
            state       <= state_next;
            p1_score    <= p1_next;
            p2_score    <= p2_next;
            o_game_over <= (state_next != PLAYING);
        end
    end

    assign o_p1_score = p1_score;
    assign o_p2_score = p2_score;

    logic show_p1, show_p2;

`ifdef SCORE_FLASH_EN
    logic [31:0] flash_cnt;
    logic        flash_on;

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            flash_cnt <= 32'd0;
            flash_on  <= 1'b1;
        end else if (state == PLAYING) begin
            flash_cnt <= 32'd0;
            flash_on  <= 1'b1;
        end else if (flash_cnt == 32'(FLASH_DIV - 1)) begin
            flash_cnt <= 32'd0;
            flash_on  <= !flash_on;
        end else begin
            flash_cnt <= flash_cnt + 32'd1;
        end
    end

    assign show_p1 = !((state == P1_WON) && !flash_on);
    assign show_p2 = !((state == P2_WON) && !flash_on);
`else
    logic unused_flash_div;
    assign unused_flash_div = (FLASH_DIV != 0);
    assign show_p1 = 1'b1;
    assign show_p2 = 1'b1;
`endif

    // Bit order gfedcba.
    function automatic logic [6:0] seg_map(input logic [3:0] v);
        case (v)
            4'd0:    seg_map = 7'h3F;
            4'd1:    seg_map = 7'h06;
            4'd2:    seg_map = 7'h5B;
            4'd3:    seg_map = 7'h4F;
            4'd4:    seg_map = 7'h66;
            4'd5:    seg_map = 7'h6D;
            4'd6:    seg_map = 7'h7D;
            4'd7:    seg_map = 7'h07;
            4'd8:    seg_map = 7'h7F;
            4'd9:    seg_map = 7'h6F;
            default: seg_map = 7'h00;
        endcase
    endfunction

    function automatic logic seg_hit(input logic [6:0] s, input logic [9:0] rx, input logic [9:0] ry);
        seg_hit = (s[0] && ry <= 10'd3)
               || (s[1] && rx >= 10'd16 && ry <= 10'd19)
               || (s[2] && rx >= 10'd16 && ry >= 10'd16)
               || (s[3] && ry >= 10'd32)
               || (s[4] && rx <= 10'd3 && ry >= 10'd16)
               || (s[5] && rx <= 10'd3 && ry <= 10'd19)
               || (s[6] && ry >= 10'd16 && ry <= 10'd19);
    endfunction

    logic in_row, in_p1, in_p2, lit;

    // Origin comparisons come first so the 10-bit subtractions never wrap into a hit.
    assign in_row = (i_display_y_pos >= Y0) && (i_display_y_pos < Y0 + 10'd36);
    assign in_p1  = in_row && (i_display_x_pos >= X1) && (i_display_x_pos < X1 + 10'd20);
    assign in_p2  = in_row && (i_display_x_pos >= X2) && (i_display_x_pos < X2 + 10'd20);
    assign lit    = (in_p1 && show_p1 && seg_hit(seg_map(p1_score), i_display_x_pos - X1, i_display_y_pos - Y0))
                 || (in_p2 && show_p2 && seg_hit(seg_map(p2_score), i_display_x_pos - X2, i_display_y_pos - Y0));

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_red   <= 3'b000;
            o_green <= 3'b000;
            o_blue  <= 3'b000;
            o_hSync <= 1'b1;
            o_vSync <= 1'b1;
        end else begin
            o_red   <= {3{lit}};
            o_green <= {3{lit}};
            o_blue  <= {3{lit}};
            o_hSync <= i_hSync;
            o_vSync <= i_vSync;
        end
    end

endmodule

`default_nettype wire
